// File: rtl/if_stage_pkg.sv
// Shared fetch-side definitions: NOP encoding, default reset PC, memory latency,
// fetch FSM states and the buffered instruction record.
package if_stage_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          MEM_LATENCY      = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {pc, instruction} records between the
// memory response and the IF/ID register; flush empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding memory requester, fetch buffer and
// IF/ID register. Define FETCH_BUF_EN for a FETCH_BUF_DEPTH-entry prefetch FIFO.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          FETCH_BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  input  logic [31:0] Imem2proc_data,
  input  logic        Imem2proc_valid,
  output logic        proc2Imem_req,
  output logic [31:0] proc2Imem_addr,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic        if_id_valid_inst
);

  if (FETCH_BUF_DEPTH < 2 || FETCH_BUF_DEPTH > 4) begin : g_depth_check
    $error("FETCH_BUF_DEPTH must be in 2..4");
  end

`ifdef FETCH_BUF_EN
  localparam int BUF_DEPTH = FETCH_BUF_DEPTH;
`else
  localparam int BUF_DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e      state;
  fetch_state_e      state_nx;
  logic [31:0]       fetch_pc;
  fetch_entry_t      buf_in;
  fetch_entry_t      buf_head;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic              has_room;
  logic              push;
  logic              pop;
  logic              issue;

  assign buf_in = '{pc: fetch_pc, ir: Imem2proc_data};

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (ex_take_branch),
    .push_data (buf_in),
    .pop_data  (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // An outstanding request reserves a slot, so its response can never overflow.
  assign has_room = !buf_full &&
                    ((int'(buf_count) + int'(state == S_WAIT)) < BUF_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (issue) state_nx = S_WAIT;
      S_WAIT: begin
        if (Imem2proc_valid)     state_nx = S_IDLE;
        else if (ex_take_branch) state_nx = S_DROP;
      end
      S_DROP:  if (Imem2proc_valid) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pop   = !ex_take_branch && !id_stall && !buf_empty;
    push  = !ex_take_branch && (state == S_WAIT) && Imem2proc_valid;
    // A slot being popped this cycle is free before the response can return.
    issue = !rst && !ex_take_branch && (state == S_IDLE) && (has_room || pop);
  end

  assign proc2Imem_req  = issue;
  assign proc2Imem_addr = word_align(fetch_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc         <= RESET_PC;
      if_id_IR         <= NOP_INST;
      if_id_PC         <= '0;
      if_id_valid_inst <= 1'b0;
    end else if (ex_take_branch) begin
      fetch_pc         <= ex_target_pc;
      if_id_IR         <= NOP_INST;
      if_id_valid_inst <= 1'b0;
    end else begin
      if (push) fetch_pc <= fetch_pc + 32'd4;
      if (!id_stall) begin
        if (pop) begin
          if_id_IR         <= buf_head.ir;
          if_id_PC         <= buf_head.pc;
          if_id_valid_inst <= 1'b1;
        end else begin
          if_id_IR         <= NOP_INST;
          if_id_valid_inst <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table-driven reset/straight-line vectors, hand sequences for
// stall, redirect and wrap, with a scoreboard queue modelling the fetch buffer.
`timescale 1ns/1ps
module tb_if_stage;
  import if_stage_pkg::*;

`ifdef FETCH_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam int STALL_REQS = (CAP - 1 < 2) ? CAP - 1 : 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stall = 1'b0;
  logic        ex_take_branch = 1'b0;
  logic [31:0] ex_target_pc = '0;
  logic [31:0] Imem2proc_data = '0;
  logic        Imem2proc_valid = 1'b0;
  logic        proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic        if_id_valid_inst;

  logic        w_valid = 1'b0;
  logic [31:0] w_data = '0;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_ir;
  logic [31:0] w_pc;
  logic        w_vi;

  always #5 clk = ~clk;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .id_stall         (id_stall),
    .ex_take_branch   (ex_take_branch),
    .ex_target_pc     (ex_target_pc),
    .Imem2proc_data   (Imem2proc_data),
    .Imem2proc_valid  (Imem2proc_valid),
    .proc2Imem_req    (proc2Imem_req),
    .proc2Imem_addr   (proc2Imem_addr),
    .if_id_IR         (if_id_IR),
    .if_id_PC         (if_id_PC),
    .if_id_valid_inst (if_id_valid_inst)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk              (clk),
    .rst              (rst),
    .id_stall         (1'b0),
    .ex_take_branch   (1'b0),
    .ex_target_pc     (32'h0),
    .Imem2proc_data   (w_data),
    .Imem2proc_valid  (w_valid),
    .proc2Imem_req    (w_req),
    .proc2Imem_addr   (w_addr),
    .if_id_IR         (w_ir),
    .if_id_PC         (w_pc),
    .if_id_valid_inst (w_vi)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } sb_entry_t;

  typedef struct {
    logic        r;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  int errors = 0;
  int checks = 0;

  sb_entry_t   sb[$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_ir = NOP_INST;
  logic [31:0] exp_pc = '0;
  bit          exp_pc_known = 1'b0;
  bit          exp_ok = 1'b0;

  bit          mem_busy = 1'b0;
  bit          mem_drop = 1'b0;
  int          mem_left = 0;
  logic [31:0] mem_addr = '0;
  int          lat = MEM_LATENCY;

  bit          w_due = 1'b0;
  logic [31:0] w_raddr = '0;
  logic [31:0] w_exp_addr = 32'hFFFF_FFFC;
  logic [31:0] w_exp_pc = 32'hFFFF_FFFC;

  logic        cur_req = 1'b0;
  logic [31:0] cur_addr = '0;
  int          req_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_8113;
      default: return {a[19:0], 12'h013};
    endcase
  endfunction

  // One clock cycle: drive inputs, sample and check outputs, then advance the model.
  task automatic step(input logic r, input logic stall, input logic br, input logic [31:0] tgt);
    bit          mem_fire;
    logic        cw_req;
    logic [31:0] cw_addr;
    sb_entry_t   e;
    mem_fire = 1'b0;
    if (mem_busy) begin
      mem_left--;
      if (mem_left == 0) mem_fire = 1'b1;
    end
    Imem2proc_valid = mem_fire;
    Imem2proc_data  = mem_fire ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    w_valid         = w_due;
    w_data          = w_due ? ~w_raddr : 32'h0;
    rst             = r;
    id_stall        = stall;
    ex_take_branch  = br;
    ex_target_pc    = tgt;
    #1;
    cur_req  = proc2Imem_req;
    cur_addr = proc2Imem_addr;
    cw_req   = w_req;
    cw_addr  = w_addr;
    if (exp_ok) begin
      check("if_id_valid", if_id_valid_inst, exp_valid);
      check("if_id_IR", if_id_IR, exp_ir);
      if (exp_pc_known) check("if_id_PC", if_id_PC, exp_pc);
    end
    if (r) begin
      check("req_in_reset", cur_req, 1'b0);
    end else begin
      if (cur_req) begin
        check("one_outstanding", mem_busy, 1'b0);
        req_seen++;
      end
      if (cw_req) begin
        check("wrap_req_addr", cw_addr, w_exp_addr);
        w_exp_addr = w_exp_addr + 32'd4;
      end
      if (exp_ok && w_vi) begin
        check("wrap_if_id_PC", w_pc, w_exp_pc);
        check("wrap_if_id_IR", w_ir, ~w_exp_pc);
        w_exp_pc = w_exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    if (r) begin
      sb.delete();
      mem_busy     = 1'b0;
      w_due        = 1'b0;
      exp_valid    = 1'b0;
      exp_ir       = NOP_INST;
      exp_pc       = '0;
      exp_pc_known = 1'b1;
      w_exp_addr   = 32'hFFFF_FFFC;
      w_exp_pc     = 32'hFFFF_FFFC;
    end else begin
      if (br) begin
        exp_valid    = 1'b0;
        exp_ir       = NOP_INST;
        exp_pc_known = 1'b0;
        sb.delete();
        if (mem_busy) mem_drop = 1'b1;
      end else if (!stall) begin
        if (sb.size() > 0) begin
          e            = sb.pop_front();
          exp_valid    = 1'b1;
          exp_pc       = e.pc;
          exp_ir       = e.ir;
          exp_pc_known = 1'b1;
        end else begin
          exp_valid    = 1'b0;
          exp_ir       = NOP_INST;
          exp_pc_known = 1'b0;
        end
      end
      if (mem_fire) begin
        if (!mem_drop) sb.push_back('{pc: mem_addr, ir: mem_word(mem_addr)});
        mem_busy = 1'b0;
      end
      if (cur_req) begin
        mem_busy = 1'b1;
        mem_left = lat;
        mem_addr = cur_addr;
        mem_drop = 1'b0;
      end
      w_due = cw_req;
      if (cw_req) w_raddr = cw_addr;
    end
    exp_ok = 1'b1;
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    bit found;
    // reset for two cycles, then straight-line fetch with 1-cycle memory
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};

    #1;
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].r, vecs[i].stall, vecs[i].br, vecs[i].tgt);
      check($sformatf("vec%0d_req", i), cur_req, vecs[i].exp_req);
      if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), cur_addr, vecs[i].exp_addr);
    end

    // stall while IF/ID holds a valid instruction
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("pre_stall_req_addr", cur_addr, 32'hC);
    req_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (i == 0) check("stall_start_valid", if_id_valid_inst, 1'b1);
    end
    check("req_stopped_at_cap", cur_req, 1'b0);
    check("reqs_during_stall", req_seen, STALL_REQS);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    // redirect while the request for 0x8 is outstanding (2-cycle memory)
    lat = 2;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (cur_req && cur_addr == 32'h8) found = 1'b1;
    end
    check("found_req_0x8", found, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("drop_no_req", cur_req, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("redirect_req", cur_req, 1'b1);
    check("redirect_addr", cur_addr, 32'h100);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    // redirect and stall in the same cycle
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (if_id_valid_inst) found = 1'b1;
    end
    check("found_valid_before_br_stall", found, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (i == 0) check("br_stall_flush_valid", if_id_valid_inst, 1'b0);
      if (cur_req) found = 1'b1;
    end
    check("br_stall_req_seen", found, 1'b1);
    check("br_stall_req_addr", cur_addr, 32'h200);

    lat = MEM_LATENCY;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
